// File: rtl/alu_result_tx_sequencer.sv
// alu_result_tx_sequencer: serialises a captured ALU result into UART TX bytes; TX_TERM_EN appends TERM_CHAR
module alu_result_tx_sequencer #(
  parameter int DATA_W = 32,
  parameter bit MSB_FIRST = 1'b1
`ifdef TX_TERM_EN
  , parameter logic [7:0] TERM_CHAR = 8'h0A
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] result,
  input  logic              tx_done,
  output logic [7:0]        d_out,
  output logic              tx_start,
  output logic              busy,
  output logic              done,
  output logic              drop
);
  localparam int NBYTES = DATA_W / 8;
  localparam int CW = $clog2(NBYTES + 1);
`ifdef TX_TERM_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT, TERM_SEND, TERM_WAIT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
`endif
  state_t state;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [CW-1:0] cnt;
  logic last;
  function automatic logic [7:0] head(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1 -: 8] : v[7:0];
  endfunction
  always_comb begin
    sr_nxt = MSB_FIRST ? sr << 8 : sr >> 8;
    last = cnt == CW'(NBYTES - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      d_out <= '0;
      tx_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done <= 1'b0;
      drop <= start && state != IDLE;
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          sr <= result;
          cnt <= '0;
          d_out <= head(result);
          tx_start <= 1'b1;
          busy <= 1'b1;
        end
        SEND: state <= WAIT;
        WAIT: if (tx_done) begin
          if (!last) begin
            state <= SEND;
            cnt <= cnt + 1'b1;
            sr <= sr_nxt;
            d_out <= head(sr_nxt);
            tx_start <= 1'b1;
          end else begin
`ifdef TX_TERM_EN
            state <= TERM_SEND;
            d_out <= TERM_CHAR;
            tx_start <= 1'b1;
`else
            state <= DONE;
            done <= 1'b1;
`endif
          end
        end
`ifdef TX_TERM_EN
        TERM_SEND: state <= TERM_WAIT;
        TERM_WAIT: if (tx_done) begin
          state <= DONE;
          done <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_result_tx_sequencer.sv
// tb_alu_result_tx_sequencer: directed scoreboard bench for MSB-first and LSB-first instances in lockstep
module tb_alu_result_tx_sequencer;
`ifdef TX_TERM_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif
  localparam int NB = 4 + int'(TERM);
  logic clk = 1'b0, reset, start, tx_done;
  logic [31:0] result;
  logic [7:0] d_out_a, d_out_b;
  logic tx_start_a, tx_start_b, busy_a, busy_b, done_a, done_b, drop_a, drop_b;
  int total = 0, bad = 0, pulses = 0, drops = 0, p0, d0;
  logic [7:0] qa[$], qb[$];

  alu_result_tx_sequencer #(.DATA_W(32), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .result(result), .tx_done(tx_done),
    .d_out(d_out_a), .tx_start(tx_start_a), .busy(busy_a), .done(done_a), .drop(drop_a));
  alu_result_tx_sequencer #(.DATA_W(32), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .result(result), .tx_done(tx_done),
    .d_out(d_out_b), .tx_start(tx_start_b), .busy(busy_b), .done(done_b), .drop(drop_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] r, input int n, input bit term);
    for (int i = 0; i < n; i++) begin
      qa.push_back(r[31-8*i -: 8]);
      qb.push_back(r[8*i +: 8]);
    end
    if (term) begin
      qa.push_back(8'h0A);
      qb.push_back(8'h0A);
    end
  endtask

  task automatic send(input logic [31:0] r);
    @(negedge clk);
    result = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_tx_start", {31'b0, tx_start_a}, 32'd1);
    chk("busy_on_start", {31'b0, busy_a}, 32'd1);
  endtask

  task automatic serve(input int nb, input bit skip, input bit fin);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      if (!(skip && i == 0)) begin
        while (tx_start_a !== 1'b1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n == 50) chk("tx_start_timeout", n, 0);
      end
      repeat (4) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (fin && i == nb - 1) begin
        chk("done_pulse", {31'b0, done_a}, 32'd1);
        chk("busy_in_done", {31'b0, busy_a}, 32'd1);
        @(negedge clk);
        chk("done_cleared", {31'b0, done_a}, 32'd0);
        chk("busy_low", {31'b0, busy_a}, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start_a) begin
        pulses++;
        chk("byte_msb", {24'h0, d_out_a}, qa.size() > 0 ? {24'h0, qa.pop_front()} : 32'h100);
      end
      if (tx_start_b) chk("byte_lsb", {24'h0, d_out_b}, qb.size() > 0 ? {24'h0, qb.pop_front()} : 32'h100);
      if (done_a) chk("done_after_last", qa.size(), 0);
      if (done_b) chk("done_b_match", {31'b0, done_b}, {31'b0, done_a});
      if (drop_a) drops++;
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tx_done = 1'b0;
    result = '0;
    repeat (2) @(negedge clk);
    chk("rst_d_out", {24'h0, d_out_a}, 0);
    chk("rst_tx_start", {31'b0, tx_start_a}, 0);
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_drop", {31'b0, drop_a}, 0);
    reset = 1'b0;
    p0 = pulses;
    push(32'h12345678, 4, TERM);
    send(32'h12345678);
    serve(NB, 1'b0, 1'b1);
    chk("basic_pulses", pulses - p0, NB);
    chk("hold_last_a", {24'h0, d_out_a}, TERM ? 32'h0A : 32'h78);
    chk("hold_last_b", {24'h0, d_out_b}, TERM ? 32'h0A : 32'h12);
    push(32'hA1B2C3D4, 4, TERM);
    send(32'hA1B2C3D4);
    serve(NB, 1'b0, 1'b1);
    chk("lsb_queue_empty", qb.size(), 0);
    p0 = pulses;
    d0 = drops;
    push(32'h00000005, 4, TERM);
    send(32'h00000005);
    @(negedge clk);
    result = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("drop_pulse", {31'b0, drop_a}, 1);
    chk("drop_pulse_b", {31'b0, drop_b}, 1);
    serve(NB, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("overlap_pulses", pulses - p0, NB);
    chk("overlap_drops", drops - d0, 1);
    chk("overlap_idle", {31'b0, busy_a}, 0);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stray_idle_busy", {31'b0, busy_a}, 0);
    chk("stray_idle_tx", {31'b0, tx_start_a}, 0);
    p0 = pulses;
    push(32'hCAFEF00D, 4, TERM);
    send(32'hCAFEF00D);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    serve(NB, 1'b1, 1'b1);
    chk("stray_pulses", pulses - p0, NB);
    push(32'hDEADBEEF, 2, 1'b0);
    send(32'hDEADBEEF);
    serve(1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_d_out", {24'h0, d_out_a}, 0);
    chk("mid_rst_busy", {31'b0, busy_a}, 0);
    chk("mid_rst_tx", {31'b0, tx_start_a}, 0);
    chk("mid_rst_done", {31'b0, done_a}, 0);
    chk("mid_rst_busy_b", {31'b0, busy_b}, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_qa", qa.size(), 0);
    chk("mid_rst_qb", qb.size(), 0);
    p0 = pulses;
    push(32'h0000002B, 4, TERM);
    send(32'h0000002B);
    serve(NB, 1'b0, 1'b1);
    chk("post_rst_pulses", pulses - p0, NB);
    chk("final_qa", qa.size(), 0);
    chk("final_qb", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_result_tx_sequencer.md
Name: alu_result_tx_sequencer

Overview:
- Sequences return of the 32-bit ALU result to the host over the UART transmitter.
- Captures the result on a start request and splits it into bytes.
- Sends each byte with a tx_start / tx_done handshake, then signals completion.
- Sits between the ALU result bus and the UART TX block, alongside the RX-side operand/opcode interface.

Parameters:
- DATA_W, 32, result width; must be a multiple of 8; NBYTES = DATA_W/8.
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first.
- TERM_CHAR, 8'h0A, terminator byte; used only when TX_TERM_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to send result; sampled every cycle.
- result  in  DATA_W  ALU result; valid in the cycle start is high.
- tx_done  in  1  one-cycle pulse from UART TX: current byte fully shifted out.
- d_out  out  8  byte presented to UART TX.
- tx_start  out  1  one-cycle pulse: UART TX loads d_out.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last byte's tx_done.
- drop  out  1  one-cycle pulse: start arrived while busy and was ignored.

Behaviour:
- Reset (async, any state): state=IDLE; d_out=0, tx_start=0, busy=0, done=0, drop=0; byte counter=0; shift register=0.
- States: IDLE, SEND, WAIT, TERM_SEND, TERM_WAIT, DONE. The TERM_* states exist only with TX_TERM_EN.
- IDLE:
  - start=1 at edge k → capture result into shift register, counter=0, go to SEND.
  - Result: tx_start=1 and busy=1 during cycle k+1.
- SEND: tx_start=1 for exactly one cycle; d_out = current byte; next state WAIT unconditionally.
- Current byte selection:
  - MSB_FIRST=1: shift-register bits [DATA_W-1:DATA_W-8], shift left 8 per byte.
  - MSB_FIRST=0: bits [7:0], shift right 8 per byte.
- WAIT: hold d_out stable; tx_start=0.
  - tx_done=1 with counter < NBYTES-1 → counter+1, shift, go to SEND.
  - tx_done=1 with counter = NBYTES-1 → go to DONE (or TERM_SEND when TX_TERM_EN).
- tx_done is sampled only in WAIT / TERM_WAIT. A tx_done in SEND, DONE or IDLE is ignored; there is no byte skipping.
- DONE: done=1 for one cycle, busy still 1; next state IDLE.
- start while busy (any state except IDLE, including DONE) → drop=1 in the following cycle. Transfer and captured data are unaffected.
- start and a final tx_done in the same cycle → the start is dropped.
- Latency, NBYTES=4, tx_done arriving immediately after each tx_start:
  - start → first tx_start: 1 cycle.
  - last tx_done → done: 1 cycle.
  - last tx_done → busy low: 2 cycles.
- d_out retains the last byte sent after the transfer, until the next capture.
- Counter width: clog2(NBYTES+1); no wrap is possible because the counter is bounded by the WAIT check.

Optional Feature:
- Macro: TX_TERM_EN.
- Defined: after the last data byte's tx_done, go to TERM_SEND (d_out=TERM_CHAR, tx_start=1 for one cycle), then TERM_WAIT. tx_done in TERM_WAIT → DONE. Total bytes per transfer = NBYTES+1.
- Undefined: the TERM states and TERM_CHAR logic are absent; last data tx_done goes directly to DONE.

Test Plan:
- Basic order, MSB_FIRST=1: result=32'h12345678, start pulse; bench returns tx_done 5 cycles after each tx_start → four tx_start pulses with d_out 8'h12, 8'h34, 8'h56, 8'h78; done pulses 1 cycle after 4th tx_done; busy low next cycle.
- MSB_FIRST=0: result=32'hA1B2C3D4 → d_out sequence 8'hD4, 8'hC3, 8'hB2, 8'hA1.
- Overlap: start with 32'h00000005, then start with 32'hFFFFFFFF two cycles later → drop pulses once; transmitted bytes 00,00,00,05; no second transfer.
- Stray handshake: tx_done asserted in IDLE and in the SEND cycle → ignored; exactly 4 tx_start pulses still occur, one per accepted tx_done in WAIT.
- Reset mid-operation: assert reset while in WAIT after byte 2 → all outputs 0 immediately, state IDLE; new start with 32'h0000002B sends 00,00,00,2B correctly.
- TX_TERM_EN defined: result=32'h0000000C → bytes 00,00,00,0C,0A; done only after 5th tx_done.
